// File: rtl/sp_lsu_pkg.sv
// Shared types for the stack-pointer load/store unit: operation encoding,
// controller states and a helper that classifies memory writes.
package sp_lsu_pkg;

  typedef enum logic [1:0] {
    OP_STRSP = 2'b00,
    OP_LDRSP = 2'b01,
    OP_PUSH  = 2'b10,
    OP_POP   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_RESP   = 2'b10
  } state_e;

  function automatic logic isWriteOp(input op_e opSel);
    return (opSel == OP_STRSP) || (opSel == OP_PUSH);
  endfunction

endpackage

// File: rtl/sp_addr_gen.sv
// Combinational address generator: effective address for each op plus the
// stack overflow/underflow checks against the legal SP window.
module sp_addr_gen
  import sp_lsu_pkg::*;
#(
  parameter int unsigned            ADDR_W   = 16,
  parameter int unsigned            IMM_W    = 9,
  parameter int unsigned            STEP     = 2,
  parameter logic [ADDR_W-1:0]      SP_INIT  = 16'h0FFE,
  parameter logic [ADDR_W-1:0]      SP_LIMIT = 16'h0800
) (
  input  op_e               op_i,
  input  logic [ADDR_W-1:0] sp_i,
  input  logic [IMM_W-1:0]  imm_i,
  output logic [ADDR_W-1:0] effAddr_o,
  output logic [ADDR_W-1:0] spDec_o,
  output logic [ADDR_W-1:0] spInc_o,
  output logic              stackFault_o
);

  logic [ADDR_W-1:0] immExt;
  logic [ADDR_W:0]   decWide;
  logic [ADDR_W:0]   incWide;
  logic              pushFault;
  logic              popFault;

  // One extra bit keeps the stack compares free of wraparound.
  assign immExt    = {{(ADDR_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};
  assign decWide   = {1'b0, sp_i} - (ADDR_W+1)'(STEP);
  assign incWide   = {1'b0, sp_i} + (ADDR_W+1)'(STEP);
  assign pushFault = decWide[ADDR_W] || (decWide[ADDR_W-1:0] < SP_LIMIT);
  assign popFault  = incWide > {1'b0, SP_INIT};
  assign spDec_o   = decWide[ADDR_W-1:0];
  assign spInc_o   = incWide[ADDR_W-1:0];

  always_comb begin
    effAddr_o    = sp_i + immExt;
    stackFault_o = 1'b0;
    case (op_i)
      OP_PUSH: begin
        effAddr_o    = decWide[ADDR_W-1:0];
        stackFault_o = pushFault;
      end
      OP_POP: begin
        effAddr_o    = sp_i;
        stackFault_o = popFault;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sp_lsu.sv
// Stack-pointer load/store unit: SP-relative loads/stores and push/pop over a
// single-outstanding request/ack memory port, with stack bound checking.
module sp_lsu
  import sp_lsu_pkg::*;
#(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       IMM_W    = 9,
  parameter int unsigned       STEP     = 2,
  parameter logic [ADDR_W-1:0] SP_INIT  = 16'h0FFE,
  parameter logic [ADDR_W-1:0] SP_LIMIT = 16'h0800
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [IMM_W-1:0]  immediate,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              spWe,
  input  logic [ADDR_W-1:0] spWdata,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [DATA_W-1:0] dataOut,
  output logic [ADDR_W-1:0] spOut,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddress,
  output logic [DATA_W-1:0] memWdata,
  input  logic [DATA_W-1:0] memRdata,
  input  logic              memAck
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [DATA_W-1:0] dataOut_q, dataOut_d;
  logic              fault_q, fault_d;

  logic [ADDR_W-1:0] effAddr;
  logic [ADDR_W-1:0] spDec;
  logic [ADDR_W-1:0] spInc;
  logic              stackFault;

  sp_addr_gen #(
    .ADDR_W  (ADDR_W),
    .IMM_W   (IMM_W),
    .STEP    (STEP),
    .SP_INIT (SP_INIT),
    .SP_LIMIT(SP_LIMIT)
  ) u_addrGen (
    .op_i        (op_e'(op)),
    .sp_i        (sp_q),
    .imm_i       (immediate),
    .effAddr_o   (effAddr),
    .spDec_o     (spDec),
    .spInc_o     (spInc),
    .stackFault_o(stackFault)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= OP_STRSP;
      addr_q    <= '0;
      wdata_q   <= '0;
      sp_q      <= SP_INIT;
      dataOut_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      sp_q      <= sp_d;
      dataOut_q <= dataOut_d;
      fault_q   <= fault_d;
    end
  end

  // SP is stable while busy, so spDec/spInc still describe the latched op.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    sp_d      = sp_q;
    dataOut_d = dataOut_q;
    fault_d   = fault_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op_e'(op);
          addr_d  = effAddr;
          wdata_d = dataIn;
          fault_d = stackFault;
          state_d = stackFault ? S_RESP : S_ACCESS;
        end else if (spWe) begin
          sp_d = spWdata;
        end
      end
      S_ACCESS: begin
        if (memAck) begin
          state_d = S_RESP;
          case (op_q)
            OP_LDRSP: dataOut_d = memRdata;
            OP_POP: begin
              dataOut_d = memRdata;
              sp_d      = spInc;
            end
            OP_PUSH:  sp_d = spDec;
            default: ;
          endcase
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_RESP);
  assign fault      = (state_q == S_RESP) && fault_q;
  assign memReq     = (state_q == S_ACCESS);
  assign memWe      = (state_q == S_ACCESS) && isWriteOp(op_q);
  assign memAddress = addr_q;
  assign memWdata   = wdata_q;
  assign dataOut    = dataOut_q;
  assign spOut      = sp_q;

endmodule

// File: tb/tb_sp_lsu.sv
// Scoreboard bench for sp_lsu: stimulus queues expected memory requests and
// responses; a memory responder and a done monitor check them independently.
module tb_sp_lsu;
  import sp_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [8:0]  immediate;
  logic [15:0] dataIn;
  logic        spWe;
  logic [15:0] spWdata;
  logic        busy, done, fault;
  logic [15:0] dataOut, spOut;
  logic        memReq, memWe;
  logic [15:0] memAddress, memWdata;
  logic [15:0] memRdata;
  logic        memAck;

  typedef struct {
    logic        fault;
    logic [15:0] data;
    logic [15:0] sp;
    int          doneCycle;
  } resp_t;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
  } memExp_t;

  resp_t       respQ[$];
  memExp_t     memQ[$];
  logic [15:0] memModel [logic [15:0]];

  int testsRun    = 0;
  int testsFailed = 0;
  int cycle       = 0;
  int ackDelay    = 0;

  sp_lsu dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .immediate(immediate),
    .dataIn(dataIn), .spWe(spWe), .spWdata(spWdata), .busy(busy), .done(done),
    .fault(fault), .dataOut(dataOut), .spOut(spOut), .memReq(memReq),
    .memWe(memWe), .memAddress(memAddress), .memWdata(memWdata),
    .memRdata(memRdata), .memAck(memAck)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic reportFail(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s (cycle %0d)", name, cycle);
  endtask

  // Memory responder: checks each new request against the expected queue and
  // acks after ackDelay request cycles; data is garbage except on the ack.
  initial begin
    bit      inReq;
    int      waitCnt;
    memExp_t cur;
    inReq    = 0;
    waitCnt  = 0;
    memAck   = 1'b0;
    memRdata = 16'hDEAD;
    forever begin
      @(negedge clk);
      memAck   = 1'b0;
      memRdata = 16'hDEAD;
      if (memReq) begin
        if (!inReq) begin
          inReq   = 1;
          waitCnt = 0;
          if (memQ.size() == 0) begin
            reportFail("unexpectedMemReq");
            cur = '{addr: memAddress, we: memWe, wdata: memWdata};
          end else begin
            cur = memQ.pop_front();
            checkOutput("memAddress", memAddress, cur.addr);
            checkOutput("memWe", memWe, cur.we);
            if (cur.we) checkOutput("memWdata", memWdata, cur.wdata);
          end
        end else begin
          checkOutput("memAddressStable", memAddress, cur.addr);
          checkOutput("memWeStable", memWe, cur.we);
        end
        if (waitCnt == ackDelay) begin
          memAck = 1'b1;
          if (cur.we) memModel[cur.addr] = cur.wdata;
          else memRdata = memModel.exists(cur.addr) ? memModel[cur.addr] : 16'hC0DE;
        end
        waitCnt++;
      end else begin
        inReq = 0;
      end
    end
  end

  // Completion monitor: every done pulse must match the oldest expected response.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (done) begin
        if (respQ.size() == 0) begin
          reportFail("unexpectedDone");
        end else begin
          r = respQ.pop_front();
          checkOutput("fault", fault, r.fault);
          checkOutput("dataOut", dataOut, r.data);
          checkOutput("spOut", spOut, r.sp);
          checkOutput("doneCycle", cycle, r.doneCycle);
          checkOutput("busyWithDone", busy, 1'b1);
        end
      end
    end
  end

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 60);
    if (busy) reportFail({name, "Timeout"});
  endtask

  task automatic setSp(input logic [15:0] value);
    @(posedge clk); #1;
    spWe    = 1'b1;
    spWdata = value;
    @(posedge clk); #1;
    spWe = 1'b0;
    @(negedge clk);
    checkOutput("spLoad", spOut, value);
  endtask

  task automatic applyStimulus(
    input op_e opSel, input logic [8:0] imm, input logic [15:0] data, input int delay,
    input logic expFault, input logic [15:0] expData, input logic [15:0] expSp,
    input logic [15:0] expAddr, input bit coSpWe, input bit pokeBusy);
    resp_t r;
    int    t;
    ackDelay = delay;
    @(posedge clk); #1;
    t = cycle;
    if (!expFault)
      memQ.push_back('{addr: expAddr, we: isWriteOp(opSel), wdata: data});
    r = '{fault: expFault, data: expData, sp: expSp,
          doneCycle: expFault ? t + 1 : t + 2 + delay};
    respQ.push_back(r);
    start     = 1'b1;
    op        = opSel;
    immediate = imm;
    dataIn    = data;
    if (coSpWe) begin
      spWe    = 1'b1;
      spWdata = 16'h0900;
    end
    @(posedge clk); #1;
    start = 1'b0;
    spWe  = 1'b0;
    if (pokeBusy) begin
      start   = 1'b1;
      op      = OP_POP;
      spWe    = 1'b1;
      spWdata = 16'h1111;
      @(posedge clk); #1;
      start = 1'b0;
      spWe  = 1'b0;
    end
    waitIdle("op");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; immediate = '0; dataIn = '0;
    spWe = 1'b0; spWdata = '0;
    memModel[16'hFFFE] = 16'h5AA5;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstDone", done, 1'b0);
    checkOutput("rstFault", fault, 1'b0);
    checkOutput("rstMemReq", memReq, 1'b0);
    checkOutput("rstMemWe", memWe, 1'b0);
    checkOutput("rstSp", spOut, 16'h0FFE);
    checkOutput("rstDataOut", dataOut, 16'h0000);

    applyStimulus(OP_STRSP, 9'h1FC, 16'hBEEF, 2, 1'b0, 16'h0000, 16'h0FFE, 16'h0FFA, 0, 0);
    applyStimulus(OP_PUSH,  9'h000, 16'h1234, 0, 1'b0, 16'h0000, 16'h0FFC, 16'h0FFC, 0, 0);
    applyStimulus(OP_POP,   9'h000, 16'h0000, 0, 1'b0, 16'h1234, 16'h0FFE, 16'h0FFC, 0, 0);
    applyStimulus(OP_POP,   9'h000, 16'h0000, 0, 1'b1, 16'h1234, 16'h0FFE, 16'h0000, 0, 0);
    setSp(16'h0801);
    applyStimulus(OP_PUSH,  9'h000, 16'h5555, 0, 1'b1, 16'h1234, 16'h0801, 16'h0000, 0, 0);
    applyStimulus(OP_LDRSP, 9'h000, 16'h0000, 1, 1'b0, 16'hC0DE, 16'h0801, 16'h0801, 1, 0);
    setSp(16'h0002);
    applyStimulus(OP_LDRSP, 9'h1FC, 16'h0000, 0, 1'b0, 16'h5AA5, 16'h0002, 16'hFFFE, 0, 0);
    applyStimulus(OP_PUSH,  9'h000, 16'h3333, 0, 1'b1, 16'h5AA5, 16'h0002, 16'h0000, 0, 0);
    setSp(16'h0802);
    applyStimulus(OP_PUSH,  9'h000, 16'h7777, 0, 1'b0, 16'h5AA5, 16'h0800, 16'h0800, 0, 0);
    setSp(16'h0FFE);
    applyStimulus(OP_PUSH,  9'h000, 16'hABCD, 2, 1'b0, 16'h5AA5, 16'h0FFC, 16'h0FFC, 0, 1);

    // Abandon a read that never gets acked.
    ackDelay = 1000;
    @(posedge clk); #1;
    memQ.push_back('{addr: 16'h0FFC, we: 1'b0, wdata: 16'h0000});
    start = 1'b1; op = OP_LDRSP; immediate = 9'h000;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("accessMemReq", memReq, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abortMemReq", memReq, 1'b0);
    checkOutput("abortBusy", busy, 1'b0);
    checkOutput("abortDone", done, 1'b0);
    checkOutput("abortSp", spOut, 16'h0FFE);
    checkOutput("abortDataOut", dataOut, 16'h0000);
    repeat (5) @(negedge clk);

    checkOutput("respQueueEmpty", respQ.size(), 0);
    checkOutput("memQueueEmpty", memQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout");
    $fatal(1, "[TB] timeout");
  end

endmodule
